// File: rtl/obi_crossbar.sv
// N x M OBI crossbar: per-port address decode, per-target round-robin arbitration,
// in-order response routing via the source index prepended to the transaction ID.
module obi_crossbar #(
  parameter int unsigned NumSbrPorts  = 6,
  parameter int unsigned NumMgrPorts  = 8,
  parameter int unsigned NumMaxTrans  = 8,
  parameter int unsigned NumAddrRules = 8,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned SbrIdWidth   = 5,
  parameter int unsigned MgrIdWidth   = SbrIdWidth + $clog2(NumSbrPorts)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         testmode_i,
  input  logic [NumSbrPorts-1:0]                       sbr_req_i,
  output logic [NumSbrPorts-1:0]                       sbr_gnt_o,
  input  logic [NumSbrPorts*AddrWidth-1:0]             sbr_addr_i,
  input  logic [NumSbrPorts-1:0]                       sbr_we_i,
  input  logic [NumSbrPorts*(DataWidth/8)-1:0]         sbr_be_i,
  input  logic [NumSbrPorts*DataWidth-1:0]             sbr_wdata_i,
  input  logic [NumSbrPorts*SbrIdWidth-1:0]            sbr_aid_i,
  output logic [NumSbrPorts-1:0]                       sbr_rvalid_o,
  output logic [NumSbrPorts*DataWidth-1:0]             sbr_rdata_o,
  output logic [NumSbrPorts*SbrIdWidth-1:0]            sbr_rid_o,
  output logic [NumSbrPorts-1:0]                       sbr_err_o,
  output logic [NumMgrPorts-1:0]                       mgr_req_o,
  output logic [NumMgrPorts*AddrWidth-1:0]             mgr_addr_o,
  output logic [NumMgrPorts-1:0]                       mgr_we_o,
  output logic [NumMgrPorts*(DataWidth/8)-1:0]         mgr_be_o,
  output logic [NumMgrPorts*DataWidth-1:0]             mgr_wdata_o,
  output logic [NumMgrPorts*MgrIdWidth-1:0]            mgr_aid_o,
  input  logic [NumMgrPorts-1:0]                       mgr_gnt_i,
  input  logic [NumMgrPorts-1:0]                       mgr_rvalid_i,
  input  logic [NumMgrPorts*DataWidth-1:0]             mgr_rdata_i,
  input  logic [NumMgrPorts*MgrIdWidth-1:0]            mgr_rid_i,
  input  logic [NumMgrPorts-1:0]                       mgr_err_i,
  input  logic [NumAddrRules*(32+2*AddrWidth+1)-1:0]   addr_map_i,
  input  logic [NumSbrPorts-1:0]                       en_default_idx_i,
  input  logic [NumSbrPorts*$clog2(NumMgrPorts)-1:0]   default_idx_i
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned SelW    = $clog2(NumMgrPorts);
  localparam int unsigned TgtW    = $clog2(NumMgrPorts + 1);
  localparam int unsigned SrcW    = $clog2(NumSbrPorts);
  localparam int unsigned CntW    = $clog2(NumMaxTrans + 1);
  localparam int unsigned RuleW   = 32 + 2 * AddrWidth + 1;
  localparam int unsigned MapW    = NumAddrRules * RuleW;

  // Target value one past the last downstream port selects the internal error slave.
  localparam logic [TgtW-1:0]      ErrTgt  = TgtW'(NumMgrPorts);
  localparam logic [CntW-1:0]      CntMax  = CntW'(NumMaxTrans);
  localparam logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E);

  function automatic logic [TgtW-1:0] decode(
    input logic [AddrWidth-1:0] addr,
    input logic                 en_def,
    input logic [SelW-1:0]      def_idx,
    input logic [MapW-1:0]      map
  );
    logic [TgtW-1:0]      tgt;
    logic [AddrWidth-1:0] lo;
    logic [AddrWidth:0]   hi;
    tgt = en_def ? TgtW'(def_idx) : ErrTgt;
    // Scan from the highest rule down so the lowest-numbered match is the last write.
    for (int r = NumAddrRules - 1; r >= 0; r--) begin
      hi = map[r*RuleW +: AddrWidth+1];
      lo = map[r*RuleW+AddrWidth+1 +: AddrWidth];
      if (addr >= lo && {1'b0, addr} < hi) tgt = TgtW'(map[r*RuleW+2*AddrWidth+1 +: SelW]);
    end
    return tgt;
  endfunction

  function automatic logic [SrcW-1:0] rr_pick(
    input logic [NumSbrPorts-1:0] req,
    input logic [SrcW-1:0]        ptr
  );
    logic [SrcW-1:0] win;
    logic [SrcW:0]   sum;
    logic            found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NumSbrPorts; k++) begin
      sum = {1'b0, ptr} + (SrcW+1)'(k);
      if (sum >= (SrcW+1)'(NumSbrPorts)) sum = sum - (SrcW+1)'(NumSbrPorts);
      if (!found && req[sum[SrcW-1:0]]) begin
        win   = sum[SrcW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  logic [TgtW-1:0]        w_tgt      [NumSbrPorts];
  logic [NumSbrPorts-1:0] w_ok;
  logic [NumSbrPorts-1:0] w_fwd      [NumMgrPorts];
  logic [SrcW-1:0]        w_win      [NumMgrPorts];
  logic                   w_unused;

  logic [CntW-1:0]        r_cnt      [NumSbrPorts];
  logic [TgtW-1:0]        r_tgt      [NumSbrPorts];
  logic [NumSbrPorts-1:0] r_err_valid;
  logic [SbrIdWidth-1:0]  r_err_id   [NumSbrPorts];
  logic [SrcW-1:0]        r_ptr      [NumMgrPorts];
  logic [NumMgrPorts-1:0] r_lock;
  logic [SrcW-1:0]        r_lock_idx [NumMgrPorts];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_unused = testmode_i;
    for (int r = 0; r < NumAddrRules; r++) begin
      w_unused = w_unused ^ (^addr_map_i[r*RuleW+2*AddrWidth+1+SelW +: 32-SelW]);
    end
    for (int s = 0; s < NumSbrPorts; s++) begin
      w_tgt[s] = decode(sbr_addr_i[s*AddrWidth +: AddrWidth], en_default_idx_i[s],
                        default_idx_i[s*SelW +: SelW], addr_map_i);
      // A switch of target waits for the port to drain, keeping responses in order.
      w_ok[s]  = !rst_n && sbr_req_i[s] && (r_cnt[s] != CntMax) &&
                 (r_cnt[s] == '0 || r_tgt[s] == w_tgt[s]);
    end
  end

  always_comb begin
    for (int m = 0; m < NumMgrPorts; m++) begin
      w_fwd[m] = '0;
      for (int s = 0; s < NumSbrPorts; s++) w_fwd[m][s] = w_ok[s] && (w_tgt[s] == TgtW'(m));
      // A winner stalled on mgr_gnt_i keeps the port until its handshake.
      w_win[m]     = (r_lock[m] && w_fwd[m][r_lock_idx[m]]) ? r_lock_idx[m]
                                                            : rr_pick(w_fwd[m], r_ptr[m]);
      mgr_req_o[m] = |w_fwd[m];
    end
  end

  always_comb begin
    mgr_addr_o  = '0;
    mgr_we_o    = '0;
    mgr_be_o    = '0;
    mgr_wdata_o = '0;
    mgr_aid_o   = '0;
    sbr_gnt_o   = '0;
    for (int s = 0; s < NumSbrPorts; s++) begin
      if (w_ok[s] && w_tgt[s] == ErrTgt) sbr_gnt_o[s] = 1'b1;
    end
    for (int m = 0; m < NumMgrPorts; m++) begin
      for (int s = 0; s < NumSbrPorts; s++) begin
        if (w_win[m] == SrcW'(s)) begin
          mgr_addr_o[m*AddrWidth +: AddrWidth]    = sbr_addr_i[s*AddrWidth +: AddrWidth];
          mgr_we_o[m]                             = sbr_we_i[s];
          mgr_be_o[m*BeWidth +: BeWidth]          = sbr_be_i[s*BeWidth +: BeWidth];
          mgr_wdata_o[m*DataWidth +: DataWidth]   = sbr_wdata_i[s*DataWidth +: DataWidth];
          mgr_aid_o[m*MgrIdWidth +: MgrIdWidth]   = {SrcW'(s), sbr_aid_i[s*SbrIdWidth +: SbrIdWidth]};
          if (mgr_req_o[m] && mgr_gnt_i[m]) sbr_gnt_o[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sbr_rvalid_o = r_err_valid;
    sbr_rdata_o  = '0;
    sbr_rid_o    = '0;
    sbr_err_o    = r_err_valid;
    for (int s = 0; s < NumSbrPorts; s++) begin
      if (r_err_valid[s]) begin
        sbr_rdata_o[s*DataWidth +: DataWidth]  = ErrData;
        sbr_rid_o[s*SbrIdWidth +: SbrIdWidth]  = r_err_id[s];
      end
      for (int m = 0; m < NumMgrPorts; m++) begin
        if (mgr_rvalid_i[m] && mgr_rid_i[m*MgrIdWidth+SbrIdWidth +: SrcW] == SrcW'(s)) begin
          sbr_rvalid_o[s]                        = 1'b1;
          sbr_rdata_o[s*DataWidth +: DataWidth]  = mgr_rdata_i[m*DataWidth +: DataWidth];
          sbr_rid_o[s*SbrIdWidth +: SbrIdWidth]  = mgr_rid_i[m*MgrIdWidth +: SbrIdWidth];
          sbr_err_o[s]                           = mgr_err_i[m];
        end
      end
    end
    if (rst_n) sbr_rvalid_o = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_err_valid <= '0;
      for (int s = 0; s < NumSbrPorts; s++) begin
        r_cnt[s]    <= '0;
        r_tgt[s]    <= '0;
        r_err_id[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NumSbrPorts; s++) begin
        case ({sbr_gnt_o[s], sbr_rvalid_o[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + CntW'(1);
          2'b01:   r_cnt[s] <= r_cnt[s] - CntW'(1);
          default: r_cnt[s] <= r_cnt[s];
        endcase
        if (sbr_gnt_o[s]) r_tgt[s] <= w_tgt[s];
        r_err_valid[s] <= sbr_gnt_o[s] && (w_tgt[s] == ErrTgt);
        if (sbr_gnt_o[s]) r_err_id[s] <= sbr_aid_i[s*SbrIdWidth +: SbrIdWidth];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_lock <= '0;
      for (int m = 0; m < NumMgrPorts; m++) begin
        r_ptr[m]      <= '0;
        r_lock_idx[m] <= '0;
      end
    end else begin
      for (int m = 0; m < NumMgrPorts; m++) begin
        if (mgr_req_o[m] && mgr_gnt_i[m]) begin
          r_ptr[m]  <= (w_win[m] == SrcW'(NumSbrPorts - 1)) ? '0 : w_win[m] + SrcW'(1);
          r_lock[m] <= 1'b0;
        end else begin
          r_lock[m] <= mgr_req_o[m];
          if (mgr_req_o[m]) r_lock_idx[m] <= w_win[m];
        end
      end
    end
  end

endmodule

// File: tb/tb_obi_crossbar.sv
// Directed bench for obi_crossbar: decode, boundaries, error slave, default route,
// round-robin fairness, in-order stall and outstanding limit.
module tb_obi_crossbar;

  localparam int S     = 6;
  localparam int M     = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int SIW   = 5;
  localparam int MIW   = 8;
  localparam int SELW  = 3;
  localparam int NR    = 8;
  localparam int RULEW = 32 + 2 * AW + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 testmode_i;
  logic [S-1:0]         sbr_req_i;
  logic [S-1:0]         sbr_gnt_o;
  logic [S*AW-1:0]      sbr_addr_i;
  logic [S-1:0]         sbr_we_i;
  logic [S*BW-1:0]      sbr_be_i;
  logic [S*DW-1:0]      sbr_wdata_i;
  logic [S*SIW-1:0]     sbr_aid_i;
  logic [S-1:0]         sbr_rvalid_o;
  logic [S*DW-1:0]      sbr_rdata_o;
  logic [S*SIW-1:0]     sbr_rid_o;
  logic [S-1:0]         sbr_err_o;
  logic [M-1:0]         mgr_req_o;
  logic [M*AW-1:0]      mgr_addr_o;
  logic [M-1:0]         mgr_we_o;
  logic [M*BW-1:0]      mgr_be_o;
  logic [M*DW-1:0]      mgr_wdata_o;
  logic [M*MIW-1:0]     mgr_aid_o;
  logic [M-1:0]         mgr_gnt_i;
  logic [M-1:0]         mgr_rvalid_i;
  logic [M*DW-1:0]      mgr_rdata_i;
  logic [M*MIW-1:0]     mgr_rid_i;
  logic [M-1:0]         mgr_err_i;
  logic [NR*RULEW-1:0]  addr_map_i;
  logic [S-1:0]         en_default_idx_i;
  logic [S*SELW-1:0]    default_idx_i;

  int total = 0;
  int bad   = 0;

  obi_crossbar dut (
    .clk(clk), .rst_n(rst_n), .testmode_i(testmode_i),
    .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o), .sbr_addr_i(sbr_addr_i),
    .sbr_we_i(sbr_we_i), .sbr_be_i(sbr_be_i), .sbr_wdata_i(sbr_wdata_i),
    .sbr_aid_i(sbr_aid_i), .sbr_rvalid_o(sbr_rvalid_o), .sbr_rdata_o(sbr_rdata_o),
    .sbr_rid_o(sbr_rid_o), .sbr_err_o(sbr_err_o),
    .mgr_req_o(mgr_req_o), .mgr_addr_o(mgr_addr_o), .mgr_we_o(mgr_we_o),
    .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o), .mgr_aid_o(mgr_aid_o),
    .mgr_gnt_i(mgr_gnt_i), .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i),
    .mgr_rid_i(mgr_rid_i), .mgr_err_i(mgr_err_i),
    .addr_map_i(addr_map_i), .en_default_idx_i(en_default_idx_i),
    .default_idx_i(default_idx_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbr_req_i        = '0;
    sbr_addr_i       = '0;
    sbr_we_i         = '0;
    sbr_be_i         = '0;
    sbr_wdata_i      = '0;
    sbr_aid_i        = '0;
    mgr_gnt_i        = '1;
    mgr_rvalid_i     = '0;
    mgr_rdata_i      = '0;
    mgr_rid_i        = '0;
    mgr_err_i        = '0;
    en_default_idx_i = '0;
    default_idx_i    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    idle();
    cyc();
    cyc();
    rst_n = 1'b0;
  endtask

  task automatic set_req(input int s, input logic [31:0] addr, input logic we,
                         input logic [4:0] aid, input logic [31:0] wdata);
    sbr_req_i[s]             = 1'b1;
    sbr_addr_i[s*AW +: AW]   = addr;
    sbr_we_i[s]              = we;
    sbr_be_i[s*BW +: BW]     = 4'hF;
    sbr_wdata_i[s*DW +: DW]  = wdata;
    sbr_aid_i[s*SIW +: SIW]  = aid;
  endtask

  task automatic respond(input int m, input logic [7:0] rid, input logic [31:0] rdata,
                         input logic err);
    mgr_rvalid_i[m]           = 1'b1;
    mgr_rid_i[m*MIW +: MIW]   = rid;
    mgr_rdata_i[m*DW +: DW]   = rdata;
    mgr_err_i[m]              = err;
  endtask

  // Map: mgr k owns [bnd[k], bnd[k+1]); 0x11000 and above is unmapped.
  logic [31:0] bnd [9] = '{32'h0, 32'h2000, 32'h4000, 32'h6300, 32'h8000,
                           32'hA000, 32'hC000, 32'h10000, 32'h11000};

  initial begin
    testmode_i = 1'b0;
    rst_n      = 1'b1;
    addr_map_i = '0;
    for (int r = 0; r < NR; r++)
      addr_map_i[r*RULEW +: RULEW] = {32'(r), bnd[r], {1'b0, bnd[r+1]}};
    idle();
    cyc();

    // Outputs held low while reset is asserted, even with live request and response.
    set_req(0, 32'h1100, 1'b0, 5'd2, 32'h0);
    respond(0, 8'h02, 32'h1, 1'b0);
    #1;
    check("rst_gnt", 64'(sbr_gnt_o), 64'h0);
    check("rst_mreq", 64'(mgr_req_o), 64'h0);
    check("rst_rvalid", 64'(sbr_rvalid_o), 64'h0);
    do_reset();

    // Port 0 write to mgr 0.
    set_req(0, 32'h1100, 1'b1, 5'd2, 32'hDEADBEEF);
    #1;
    check("wr_mreq", 64'(mgr_req_o), 64'h01);
    check("wr_we", 64'(mgr_we_o[0]), 64'h1);
    check("wr_aid", 64'(mgr_aid_o[0 +: MIW]), 64'h02);
    check("wr_addr", 64'(mgr_addr_o[0 +: AW]), 64'h1100);
    check("wr_data", 64'(mgr_wdata_o[0 +: DW]), 64'hDEADBEEF);
    check("wr_be", 64'(mgr_be_o[0 +: BW]), 64'hF);
    check("wr_gnt", 64'(sbr_gnt_o), 64'h01);
    cyc();
    idle();
    respond(0, 8'h02, 32'h0, 1'b0);
    #1;
    check("wr_rvalid", 64'(sbr_rvalid_o), 64'h01);
    check("wr_rid", 64'(sbr_rid_o[0 +: SIW]), 64'h2);
    check("wr_err", 64'(sbr_err_o), 64'h0);
    do_reset();

    // Port 5 read from mgr 6; ID carries the source index.
    set_req(5, 32'hE100, 1'b0, 5'd2, 32'h0);
    #1;
    check("rd5_mreq", 64'(mgr_req_o), 64'h40);
    check("rd5_aid", 64'(mgr_aid_o[6*MIW +: MIW]), 64'hA2);
    check("rd5_gnt", 64'(sbr_gnt_o), 64'h20);
    cyc();
    idle();
    respond(6, 8'hA2, 32'h12345678, 1'b0);
    #1;
    check("rd5_rvalid", 64'(sbr_rvalid_o), 64'h20);
    check("rd5_rdata", 64'(sbr_rdata_o[5*DW +: DW]), 64'h12345678);
    check("rd5_rid", 64'(sbr_rid_o[5*SIW +: SIW]), 64'h2);
    do_reset();

    // Rule boundaries (end exclusive).
    set_req(2, 32'h62FC, 1'b0, 5'd0, 32'h0);
    set_req(3, 32'h6300, 1'b0, 5'd0, 32'h0);
    set_req(4, 32'h10FFC, 1'b0, 5'd0, 32'h0);
    #1;
    check("bnd_mreq", 64'(mgr_req_o), 64'h8C);
    check("bnd_addr3", 64'(mgr_addr_o[3*AW +: AW]), 64'h6300);
    check("bnd_aid7", 64'(mgr_aid_o[7*MIW +: MIW]), 64'h80);
    do_reset();

    // Unmapped address, no default: error slave.
    set_req(1, 32'h11000, 1'b0, 5'd7, 32'h0);
    #1;
    check("err_gnt", 64'(sbr_gnt_o), 64'h02);
    check("err_mreq", 64'(mgr_req_o), 64'h0);
    cyc();
    idle();
    #1;
    check("err_rvalid", 64'(sbr_rvalid_o), 64'h02);
    check("err_err", 64'(sbr_err_o), 64'h02);
    check("err_rdata", 64'(sbr_rdata_o[1*DW +: DW]), 64'hBADCAB1E);
    check("err_rid", 64'(sbr_rid_o[1*SIW +: SIW]), 64'h7);
    cyc();
    check("err_done", 64'(sbr_rvalid_o), 64'h0);
    do_reset();

    // Default route: unmapped goes to mgr 4, mapped address still decodes normally.
    en_default_idx_i = 6'b000110;
    default_idx_i[1*SELW +: SELW] = 3'd4;
    default_idx_i[2*SELW +: SELW] = 3'd4;
    set_req(1, 32'h12000, 1'b0, 5'd0, 32'h0);
    set_req(2, 32'h1100, 1'b0, 5'd0, 32'h0);
    #1;
    check("def_mreq", 64'(mgr_req_o), 64'h11);
    check("def_aid4", 64'(mgr_aid_o[4*MIW +: MIW]), 64'h20);
    do_reset();

    // All six ports on mgr 3: strict rotation 0..5 then repeat.
    for (int s = 0; s < S; s++) set_req(s, 32'h6400 + 32'(s * 4), 1'b0, 5'(s), 32'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), 64'(sbr_gnt_o), 64'(6'b1 << (i % 6)));
      cyc();
    end
    do_reset();

    // Winner waiting on mgr_gnt_i is not displaced by a newcomer.
    mgr_gnt_i[3] = 1'b0;
    set_req(3, 32'h6400, 1'b0, 5'd9, 32'h0);
    #1;
    check("lock_aid0", 64'(mgr_aid_o[3*MIW +: MIW]), 64'h69);
    cyc();
    set_req(1, 32'h6500, 1'b0, 5'd1, 32'h0);
    #1;
    check("lock_aid1", 64'(mgr_aid_o[3*MIW +: MIW]), 64'h69);
    mgr_gnt_i[3] = 1'b1;
    #1;
    check("lock_gnt", 64'(sbr_gnt_o), 64'h08);
    cyc();
    sbr_req_i[3] = 1'b0;
    #1;
    check("lock_next", 64'(sbr_gnt_o), 64'h02);
    do_reset();

    // In-order stall: switch to mgr 1 waits for three responses from mgr 0.
    set_req(0, 32'h0100, 1'b0, 5'd1, 32'h0);
    cyc();
    cyc();
    cyc();
    sbr_addr_i[0 +: AW] = 32'h2100;
    #1;
    check("ord_stall", 64'(mgr_req_o[1]), 64'h0);
    check("ord_gnt", 64'(sbr_gnt_o[0]), 64'h0);
    for (int k = 0; k < 3; k++) begin
      respond(0, 8'h01, 32'(k), 1'b0);
      #1;
      check($sformatf("ord_rsp%0d", k), 64'({sbr_rvalid_o[0], mgr_req_o[1]}), 64'b10);
      cyc();
    end
    mgr_rvalid_i = '0;
    #1;
    check("ord_go", 64'(mgr_req_o[1]), 64'h1);
    check("ord_go_gnt", 64'(sbr_gnt_o[0]), 64'h1);
    do_reset();

    // Outstanding limit: 8 granted, 9th stalls until a response frees a slot.
    set_req(2, 32'hA100, 1'b0, 5'd4, 32'h0);
    for (int i = 0; i < 9; i++) begin
      #1;
      check($sformatf("max_gnt%0d", i), 64'(sbr_gnt_o[2]), 64'(i < 8));
      cyc();
    end
    respond(5, 8'h44, 32'h0, 1'b0);
    #1;
    check("max_full", 64'(sbr_gnt_o[2]), 64'h0);
    check("max_rvalid", 64'(sbr_rvalid_o), 64'h04);
    cyc();
    mgr_rvalid_i = '0;
    #1;
    check("max_free", 64'(sbr_gnt_o[2]), 64'h1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
